// File: rtl/conv_pkg.sv
// Shared types and constants for the K=3, rate-1/2 convolutional frame sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    TAIL  = 2'd3
  } state_e;

  localparam int TAIL_LEN = 2;
  localparam int BYTE_W   = 8;

  // Generator taps are ordered {b, d1, d2}
  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G0 = 3'b101;

  function automatic logic gen_parity(input logic [2:0] g, input logic [2:0] taps);
    return ^(g & taps);
  endfunction

endpackage

// File: rtl/conv_trellis_step.sv
// One trellis step: parity pair and next {d2,d1} from the current bit and state.
module conv_trellis_step
  import conv_pkg::*;
(
  input  logic       b,
  input  logic [1:0] trellis,
  output logic [1:0] pair,
  output logic [1:0] trellis_nxt
);

  logic [2:0] taps_s;

  // Encoder taps and shift of the two-bit history
  always_comb begin
    taps_s      = {b, trellis[0], trellis[1]};
    pair        = {gen_parity(G1, taps_s), gen_parity(G0, taps_s)};
    trellis_nxt = {trellis[0], b};
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Byte-to-trellis frame sequencer with registered valid/ready parity output.
// Define CONV_TAIL_EN to append two zero tail pairs per frame; otherwise frames are truncated.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int FCNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        parities,
  output logic              out_first,
  output logic              out_last,
  output logic [FCNT_W-1:0] frames_done
);

  state_e            state_r, state_nxt_s;
  logic [BYTE_W-1:0] shift_r;
  logic [2:0]        bit_cnt_r;
  logic              last_flag_r, first_pend_r;
  logic [1:0]        trellis_r, trellis_nxt_s, pair_s;
  logic              adv_s, emit_s, load_s, done_s, bit_s, in_ready_s;
  logic              out_valid_r, out_first_r, out_last_r;
  logic [1:0]        parities_r;
  logic [FCNT_W-1:0] frames_done_r;
`ifdef CONV_TAIL_EN
  logic              tail_cnt_r;
`endif

  conv_trellis_step u_step (
    .b           (bit_s),
    .trellis     (trellis_r),
    .pair        (pair_s),
    .trellis_nxt (trellis_nxt_s)
  );

  assign adv_s = !out_valid_r | out_ready;

  // Next-state, handshake and emit decode
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    emit_s      = 1'b0;
    load_s      = 1'b0;
    done_s      = 1'b0;
    bit_s       = 1'b0;
    case (state_r)
      IDLE, WAIT: begin
        in_ready_s = 1'b1;
        load_s     = in_valid;
        if (in_valid) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      SHIFT: begin
        bit_s  = shift_r[BYTE_W-1];
        emit_s = adv_s;
        if (adv_s && (bit_cnt_r == 3'd0)) begin
          if (last_flag_r) begin
`ifdef CONV_TAIL_EN
            state_nxt_s = TAIL;
`else
            done_s      = 1'b1;
            state_nxt_s = IDLE;
`endif
          end else begin
            // Back-to-back bytes are accepted on the last bit so no bubble appears
            in_ready_s = 1'b1;
            load_s     = in_valid;
            if (in_valid) begin
              state_nxt_s = SHIFT;
            end else begin
              state_nxt_s = WAIT;
            end
          end
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      TAIL: begin
`ifdef CONV_TAIL_EN
        emit_s = adv_s;
        if (adv_s && (tail_cnt_r == 1'(TAIL_LEN - 1))) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = TAIL;
        end
`else
        state_nxt_s = IDLE;
`endif
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Byte shifter, bit counter, frame flags and trellis history
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_r      <= {BYTE_W{1'b0}};
      bit_cnt_r    <= 3'd0;
      last_flag_r  <= 1'b0;
      first_pend_r <= 1'b0;
      trellis_r    <= 2'b00;
    end else begin
      if (load_s) begin
        shift_r     <= in_data;
        bit_cnt_r   <= 3'd7;
        last_flag_r <= in_last;
      end else if (emit_s && (state_r == SHIFT)) begin
        shift_r   <= {shift_r[BYTE_W-2:0], 1'b0};
        bit_cnt_r <= bit_cnt_r - 3'd1;
      end
      if (load_s && (state_r == IDLE)) begin
        first_pend_r <= 1'b1;
        trellis_r    <= 2'b00;
      end else if (emit_s) begin
        first_pend_r <= 1'b0;
        trellis_r    <= trellis_nxt_s;
      end
    end
  end

`ifdef CONV_TAIL_EN
  // Tail pair counter, cleared whenever the FSM is outside TAIL
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tail_cnt_r <= 1'b0;
    end else if (state_r == TAIL) begin
      if (emit_s) tail_cnt_r <= tail_cnt_r + 1'b1;
    end else begin
      tail_cnt_r <= 1'b0;
    end
  end
`endif

  // Output pair register and completed-frame counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_r   <= 1'b0;
      parities_r    <= 2'b00;
      out_first_r   <= 1'b0;
      out_last_r    <= 1'b0;
      frames_done_r <= {FCNT_W{1'b0}};
    end else begin
      if (adv_s) begin
        out_valid_r <= emit_s;
        out_first_r <= emit_s & first_pend_r;
        out_last_r  <= emit_s & done_s;
        if (emit_s) parities_r <= pair_s;
      end
      if (done_s) frames_done_r <= frames_done_r + {{(FCNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign parities    = parities_r;
  assign out_first   = out_first_r;
  assign out_last    = out_last_r;
  assign frames_done = frames_done_r;

endmodule
